vec_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter on the picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Shares a single memory port between the picorv32 core port and the vector coprocessor load/store port (vlse/vsse traffic).
- Fixed priority with an anti-starvation promotion counter, a per-transaction timeout flag, and a one-cycle arbitration gap between transactions.

---
 rtl/vec_mem_pkg.sv | 16 +
 rtl/vec_mem_prio_sel.sv | 50 +++++
 rtl/vec_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_vec_mem_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector/CPU memory arbiter family.
// Holds the arbiter state encoding, port identifiers and the read strobe value.
package vec_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_VEC = 2'd2
  } arb_state_t;

  localparam logic       PORT_CPU   = 1'b0;
  localparam logic       PORT_VEC   = 1'b1;
  localparam logic [3:0] WSTRB_READ = 4'b0000;
  localparam int         WAIT_W     = 4;

endpackage

// File: rtl/vec_mem_prio_sel.sv
// Combinational winner selection for the two-port memory arbiter.
// Ports:
//   cpu_valid, vec_valid : pending requests
//   vec_high_prio        : 1 = vector port is the default winner
//   promote              : low-priority port has waited MAX_WAIT lost grants
//   req                  : any request pending
//   winner               : PORT_CPU / PORT_VEC
//   wait_inc, wait_clr   : wait counter update for this grant
module vec_mem_prio_sel
  import vec_mem_pkg::*;
(
  input  logic cpu_valid,
  input  logic vec_valid,
  input  logic vec_high_prio,
  input  logic promote,
  output logic req,
  output logic winner,
  output logic wait_inc,
  output logic wait_clr
);

  logic low_valid;
  logic high_valid;
  logic low_port;

  assign low_port   = vec_high_prio ? PORT_CPU : PORT_VEC;
  assign low_valid  = vec_high_prio ? cpu_valid : vec_valid;
  assign high_valid = vec_high_prio ? vec_valid : cpu_valid;

  always_comb begin
    req      = cpu_valid | vec_valid;
    winner   = ~low_port;
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    if (high_valid && low_valid) begin
      if (promote) begin
        winner   = low_port;
        wait_clr = 1'b1;
      end else begin
        winner   = ~low_port;
        wait_inc = 1'b1;
      end
    end else if (low_valid) begin
      // Any grant to the low-priority port restarts its starvation count.
      winner   = low_port;
      wait_clr = 1'b1;
    end
  end

endmodule

// File: rtl/vec_mem_arbiter.sv
// Two-master (CPU core, vector coprocessor) to one-slave arbiter on the
// picorv32 native memory interface.
// Ports:
//   clk, reset          : clock, async active-high reset
//   cpu_mem_*           : core request port (valid/instr/addr/wdata/wstrb in,
//                         ready/rdata out)
//   vec_mem_*           : coprocessor request port (valid/addr/wdata/wstrb in,
//                         ready/rdata out)
//   mem_*               : registered request to memory, ready/rdata back
//   grant_vec           : vector port owns the bus
//   busy                : arbiter not idle
//   err_timeout         : sticky, a grant waited TIMEOUT cycles for mem_ready
module vec_mem_arbiter
  import vec_mem_pkg::*;
#(
  parameter bit VEC_HIGH_PRIO = 1'b1,
  parameter int MAX_WAIT      = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_vec,
  output logic        busy,
  output logic        err_timeout
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        tout_cnt;
  logic              req;
  logic              winner;
  logic              wait_inc;
  logic              wait_clr;
  logic              granted;

  vec_mem_prio_sel u_prio_sel (
    .cpu_valid     (cpu_mem_valid),
    .vec_valid     (vec_mem_valid),
    .vec_high_prio (VEC_HIGH_PRIO),
    .promote       (wait_cnt == WAIT_W'(MAX_WAIT)),
    .req           (req),
    .winner        (winner),
    .wait_inc      (wait_inc),
    .wait_clr      (wait_clr)
  );

  assign granted = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (req) state_nxt = (winner == PORT_VEC) ? GNT_VEC : GNT_CPU;
      GNT_CPU, GNT_VEC: if (mem_ready) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= WSTRB_READ;
      grant_vec   <= 1'b0;
      err_timeout <= 1'b0;
      wait_cnt    <= '0;
      tout_cnt    <= '0;
    end else if (!granted && req) begin
      mem_valid <= 1'b1;
      grant_vec <= (winner == PORT_VEC);
      mem_instr <= (winner == PORT_CPU) & cpu_mem_instr;
      mem_addr  <= (winner == PORT_VEC) ? vec_mem_addr  : cpu_mem_addr;
      mem_wdata <= (winner == PORT_VEC) ? vec_mem_wdata : cpu_mem_wdata;
      mem_wstrb <= (winner == PORT_VEC) ? vec_mem_wstrb : cpu_mem_wstrb;
      tout_cnt  <= '0;
      if (wait_clr)                     wait_cnt <= '0;
      else if (wait_inc && !(&wait_cnt)) wait_cnt <= wait_cnt + 1'b1;
    end else if (granted) begin
      if (mem_ready) begin
        mem_valid <= 1'b0;
        mem_instr <= 1'b0;
        grant_vec <= 1'b0;
      end else begin
        if (!(&tout_cnt)) tout_cnt <= tout_cnt + 1'b1;
        // Flag on the edge where the count reaches TIMEOUT; the transfer continues.
        if (tout_cnt == 8'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end

  assign busy          = granted;
  assign cpu_mem_ready = (state == GNT_CPU) & mem_ready;
  assign vec_mem_ready = (state == GNT_VEC) & mem_ready;
  assign cpu_mem_rdata = mem_rdata;
  assign vec_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
module tb_vec_mem_arbiter;

  localparam bit VEC_HIGH_PRIO = 1'b1;
  localparam int MAX_WAIT      = 4;
  localparam int TIMEOUT       = 255;

  logic        clk;
  logic        reset;
  logic        cpu_mem_valid, cpu_mem_instr;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr, vec_mem_wdata, vec_mem_rdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        grant_vec, busy, err_timeout;

  vec_mem_arbiter #(
    .VEC_HIGH_PRIO (VEC_HIGH_PRIO),
    .MAX_WAIT      (MAX_WAIT),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_mem_valid (cpu_mem_valid),
    .cpu_mem_instr (cpu_mem_instr),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_mem_wstrb (cpu_mem_wstrb),
    .cpu_mem_ready (cpu_mem_ready),
    .cpu_mem_rdata (cpu_mem_rdata),
    .vec_mem_valid (vec_mem_valid),
    .vec_mem_addr  (vec_mem_addr),
    .vec_mem_wdata (vec_mem_wdata),
    .vec_mem_wstrb (vec_mem_wstrb),
    .vec_mem_ready (vec_mem_ready),
    .vec_mem_rdata (vec_mem_rdata),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .grant_vec     (grant_vec),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave and the independent reference image used for expected read data.
  logic [31:0] mem_arr [1024];
  logic [31:0] ref_mem [1024];
  int          mem_lat  = 0;
  bit          rand_lat = 1'b0;

  initial begin
    int  lat_cnt;
    int  cur_lat;
    bit  started;
    int  idx;
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat_cnt   = 0;
    cur_lat   = 0;
    started   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        started   = 1'b0;
      end else if (reset !== 1'b0 || mem_valid !== 1'b1) begin
        lat_cnt = 0;
        started = 1'b0;
      end else begin
        if (!started) begin
          started = 1'b1;
          lat_cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (lat_cnt >= cur_lat) begin
          idx       = int'(mem_addr[11:2]);
          mem_rdata = mem_arr[idx];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem_arr[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          mem_ready = 1'b1;
          started   = 1'b0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  // Grant log: one entry per rising mem_valid (1 = vector), with its cycle number.
  bit grant_q [$];
  int gtime_q [$];
  int cyc = 0;

  initial begin
    logic prev_mv;
    prev_mv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset === 1'b0 && mem_valid === 1'b1 && prev_mv !== 1'b1) begin
        grant_q.push_back(grant_vec);
        gtime_q.push_back(cyc);
      end
      prev_mv = mem_valid;
    end
  end

  // Per-cycle protocol observer: held request fields, ready exclusivity, instr=0 on vector grants.
  initial begin
    bit          hold;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b0) begin
        hold = 1'b0;
      end else if (mem_valid === 1'b1) begin
        if (hold) begin
          chk("hold_addr", mem_addr, p_addr);
          chk("hold_wdata", mem_wdata, p_wdata);
          chk("hold_wstrb", {28'd0, mem_wstrb}, {28'd0, p_wstrb});
        end
        if (grant_vec) begin
          chk("vec_instr0", {31'd0, mem_instr}, 32'd0);
          chk("cpu_rdy_off", {31'd0, cpu_mem_ready}, 32'd0);
        end else begin
          chk("vec_rdy_off", {31'd0, vec_mem_ready}, 32'd0);
        end
        hold    = !mem_ready;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
        p_wstrb = mem_wstrb;
      end else begin
        hold = 1'b0;
        chk("idle_rdy", {30'd0, cpu_mem_ready, vec_mem_ready}, 32'd0);
      end
    end
  end

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int idx;
    idx = int'(addr[11:2]);
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
  endtask

  task automatic cpu_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr);
    bit          got;
    logic [31:0] rd;
    cpu_mem_addr  = addr;
    cpu_mem_wdata = wdata;
    cpu_mem_wstrb = wstrb;
    cpu_mem_instr = instr;
    cpu_mem_valid = 1'b1;
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cpu_mem_ready) begin
        got = 1'b1;
        rd  = cpu_mem_rdata;
      end
    end
    chk("cpu_ready_seen", {31'd0, got}, 32'd1);
    if (got) begin
      if (wstrb == 4'b0000) chk("cpu_rdata", rd, ref_mem[addr[11:2]]);
      else                  ref_write(addr, wdata, wstrb);
      @(posedge clk);
      #1;
    end
    cpu_mem_valid = 1'b0;
  endtask

  task automatic vec_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    bit          got;
    logic [31:0] rd;
    vec_mem_addr  = addr;
    vec_mem_wdata = wdata;
    vec_mem_wstrb = wstrb;
    vec_mem_valid = 1'b1;
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #1;
      if (vec_mem_ready) begin
        got = 1'b1;
        rd  = vec_mem_rdata;
      end
    end
    chk("vec_ready_seen", {31'd0, got}, 32'd1);
    if (got) begin
      if (wstrb == 4'b0000) chk("vec_rdata", rd, ref_mem[addr[11:2]]);
      else                  ref_write(addr, wdata, wstrb);
      @(posedge clk);
      #1;
    end
    vec_mem_valid = 1'b0;
  endtask

  // Arbitration reference: both ports keep requesting until their counts run out.
  int m_wait = 0;
  bit exp_q [$];

  task automatic model_order(input int nc, input int nv);
    bit pick_vec;
    exp_q.delete();
    while (nc > 0 || nv > 0) begin
      if (nc > 0 && nv > 0) begin
        if (m_wait == MAX_WAIT) begin
          pick_vec = !VEC_HIGH_PRIO;
          m_wait   = 0;
        end else begin
          pick_vec = VEC_HIGH_PRIO;
          if (m_wait < 15) m_wait++;
        end
      end else begin
        pick_vec = (nv > 0);
        if (pick_vec != VEC_HIGH_PRIO) m_wait = 0;
      end
      exp_q.push_back(pick_vec);
      if (pick_vec) nv--;
      else          nc--;
    end
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_len"}, grant_q.size(), exp_q.size());
    for (int i = 0; i < grant_q.size() && i < exp_q.size(); i++)
      chk({tag, "_gnt"}, {31'd0, grant_q[i]}, {31'd0, exp_q[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [31:0] rd;
    int          nc, nv;

    reset         = 1'b1;
    cpu_mem_valid = 1'b0;
    cpu_mem_instr = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_wdata = '0;
    cpu_mem_wstrb = '0;
    vec_mem_valid = 1'b0;
    vec_mem_addr  = '0;
    vec_mem_wdata = '0;
    vec_mem_wstrb = '0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'h1000_0000 ^ (i * 32'h0001_0003);
    mem_arr[0]   = 32'h0100_0113;
    mem_arr[100] = 32'h0201_0201;
    mem_arr[200] = 32'h5555_5555;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem_arr[i];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_instr", {31'd0, mem_instr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_flags", {28'd0, grant_vec, busy, err_timeout, 1'b0}, 32'd0);
    chk("rst_ready", {30'd0, cpu_mem_ready, vec_mem_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single CPU fetch at 0x0, memory answers in the first granted cycle
    mem_lat = 0;
    @(posedge clk);
    #1;
    cpu_mem_addr  = 32'h0;
    cpu_mem_instr = 1'b1;
    cpu_mem_wstrb = 4'b0000;
    cpu_mem_valid = 1'b1;
    chk("t1_pre_valid", {30'd0, mem_valid, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("t1_mem_instr", {31'd0, mem_instr}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_busy_gv", {30'd0, busy, grant_vec}, 32'd2);
    @(negedge clk);
    #1;
    chk("t1_cpu_ready", {31'd0, cpu_mem_ready}, 32'd1);
    chk("t1_cpu_rdata", cpu_mem_rdata, 32'h0100_0113);
    chk("t1_vec_ready", {31'd0, vec_mem_ready}, 32'd0);
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    chk("t1_after_ready", {31'd0, cpu_mem_ready}, 32'd0);
    chk("t1_after_idle", {30'd0, mem_valid, busy}, 32'd0);
    m_wait = 0;

    // Simultaneous CPU fetch and vector read of 0x190
    grant_q.delete();
    gtime_q.delete();
    @(posedge clk);
    #1;
    fork
      cpu_txn(32'h4, 32'h0, 4'b0000, 1'b1);
      vec_txn(32'h190, 32'h0, 4'b0000);
    join
    model_order(1, 1);
    check_order("t2");
    if (gtime_q.size() == 2) chk("t2_gap", gtime_q[1] - gtime_q[0], 32'd2);
    else                     chk("t2_gap_count", gtime_q.size(), 32'd2);

    // Vector streams 10 reads, CPU requests continuously
    grant_q.delete();
    fork
      for (int i = 0; i < 2; i++) cpu_txn(32'h40 + 32'(i * 4), 32'h0, 4'b0000, 1'b1);
      for (int j = 0; j < 10; j++) vec_txn(32'h190 + 32'(j * 4), 32'h0, 4'b0000);
    join
    model_order(2, 10);
    check_order("t3");

    // Vector byte write at 0x320, held for a few cycles
    mem_lat = 2;
    grant_q.delete();
    vec_txn(32'h320, 32'h0000_00AB, 4'b0001);
    chk("t4_byte_write", mem_arr[200], 32'h5555_55AB);
    vec_txn(32'h320, 32'h0, 4'b0000);
    model_order(0, 2);
    check_order("t4");

    // Randomised rounds: CPU in the low 1 KiB, vector in the next 1 KiB
    rand_lat = 1'b1;
    for (int r = 0; r < 4; r++) begin
      nc = int'($urandom_range(1, 6));
      nv = int'($urandom_range(1, 12));
      grant_q.delete();
      fork
        for (int i = 0; i < nc; i++)
          cpu_txn(32'($urandom_range(0, 255)) << 2, $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000, 1'($urandom_range(0, 1)));
        for (int j = 0; j < nv; j++)
          vec_txn(32'($urandom_range(256, 511)) << 2, $urandom,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000);
      join
      model_order(nc, nv);
      check_order("rand");
    end
    rand_lat = 1'b0;

    // Timeout: memory withholds ready for 300 cycles
    mem_lat = 300;
    @(posedge clk);
    #1;
    cpu_mem_addr  = 32'h8;
    cpu_mem_instr = 1'b0;
    cpu_mem_wstrb = 4'b0000;
    cpu_mem_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_granted", {31'd0, mem_valid}, 32'd1);
    repeat (254) @(posedge clk);
    #1;
    chk("t5_err_before", {31'd0, err_timeout}, 32'd0);
    @(posedge clk);
    #1;
    chk("t5_err_at_255", {31'd0, err_timeout}, 32'd1);
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cpu_mem_ready) begin
        got = 1'b1;
        rd  = cpu_mem_rdata;
      end
    end
    chk("t5_late_ready", {31'd0, got}, 32'd1);
    chk("t5_rdata", rd, ref_mem[2]);
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
    mem_lat = 0;
    cpu_txn(32'hC, 32'h0, 4'b0000, 1'b0);
    chk("t5_err_still", {31'd0, err_timeout}, 32'd1);
    m_wait = 0;

    // Reset while the CPU owns the bus
    mem_lat = 5;
    @(posedge clk);
    #1;
    cpu_mem_addr  = 32'h10;
    cpu_mem_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_granted", {31'd0, mem_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_clear", {28'd0, mem_valid, busy, grant_vec, err_timeout}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("t6_no_ready", {31'd0, cpu_mem_ready}, 32'd0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_regrant", {29'd0, mem_valid, busy, grant_vec}, 32'd6);
    chk("t6_regrant_addr", mem_addr, 32'h10);
    got = 1'b0;
    rd  = '0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      #1;
      if (cpu_mem_ready) begin
        got = 1'b1;
        rd  = cpu_mem_rdata;
      end
    end
    chk("t6_ready", {31'd0, got}, 32'd1);
    chk("t6_rdata", rd, ref_mem[4]);
    @(posedge clk);
    #1;
    cpu_mem_valid = 1'b0;
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
